// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel filter datapath and its output packer.
package sobel_pkg;

    localparam int PIXEL_W        = 8;
    localparam int WORD_W         = 128;
    localparam int BYTES_PER_WORD = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [WORD_W-1:0]  word_t;

endpackage

// File: rtl/sobel_word_packer_if.sv
// Byte-stream input and word-stream output of the packer, bundled for port connection.
interface sobel_word_packer_if #(
    parameter int BYTES_PER_WORD = 16,
    parameter int FIFO_DEPTH     = 4
);
    import sobel_pkg::*;

    pixel_t                            data_in;
    logic                              valid_in;
    logic                              flush;
    logic [8*BYTES_PER_WORD-1:0]       word_out;
    logic [$clog2(BYTES_PER_WORD):0]   word_bytes;
    logic                              word_valid;
    logic                              word_ready;
    logic                              overflow;
    logic [$clog2(FIFO_DEPTH):0]       fifo_level;

    // Packer side: consumes bytes, produces words.
    modport master (
        input  data_in, valid_in, flush, word_ready,
        output word_out, word_bytes, word_valid, overflow, fifo_level
    );

    // Environment side: supplies bytes, accepts words.
    modport slave (
        output data_in, valid_in, flush, word_ready,
        input  word_out, word_bytes, word_valid, overflow, fifo_level
    );
endinterface

// File: rtl/sobel_word_packer_fifo.sv
// Synchronous FIFO with registered head outputs and a sticky drop flag.
module sync_fifo #(
    parameter int WIDTH = 133,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    import sobel_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             pop_ok, push_ok;

    // Next-state: storage, pointers, occupancy and the head that will be presented next cycle.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        pop_ok  = pop && valid_q;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = push && ((level_q != LW'(DEPTH)) || pop_ok);
        ovf_d   = ovf_q || (push && !push_ok);
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Reading from mem_d covers the case where the new word lands straight at the head.
        if (level_d != '0) begin
            valid_d = 1'b1;
            dout_d  = mem_d[rd_d];
        end else begin
            valid_d = 1'b0;
            dout_d  = '0;
        end
    end

    // State registers; reset empties the FIFO and clears the drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign valid    = valid_q;
    assign level    = level_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/sobel_word_packer.sv
// Packs the Sobel filter's byte stream into little-endian words and queues them for the host.
module sobel_word_packer #(
    parameter int BYTES_PER_WORD = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input logic               clk,
    input logic               rst,
    sobel_word_packer_if.master bus
);
    import sobel_pkg::*;

    localparam int WW = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD);
    localparam int NW = CW + 1;
    localparam int FW = WW + NW;

    logic [WW-1:0] acc_q, acc_d, acc_ins;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] eff_cnt;
    logic          complete;
    logic [FW-1:0] fifo_din, fifo_dout;

    // Lane insertion, completion detection and accumulator/counter update.
    always_comb begin
        acc_ins = acc_q;
        if (bus.valid_in) begin
            acc_ins[{cnt_q, 3'b000} +: PIXEL_W] = bus.data_in;
        end else begin
            acc_ins = acc_q;
        end
        // Count including a byte arriving this cycle, so a flush never loses it.
        eff_cnt  = {1'b0, cnt_q} + {{CW{1'b0}}, bus.valid_in};
        complete = (bus.valid_in && (cnt_q == CW'(BYTES_PER_WORD - 1))) ||
                   (bus.flush && (eff_cnt != '0));
        // Lanes above the count are already zero because acc is cleared on every completion.
        fifo_din = {eff_cnt, acc_ins};
        if (complete) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            acc_d = acc_ins;
            cnt_d = eff_cnt[CW-1:0];
        end
    end

    // Accumulator and byte counter; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (complete),
        .din      (fifo_din),
        .pop      (bus.word_ready),
        .dout     (fifo_dout),
        .valid    (bus.word_valid),
        .level    (bus.fifo_level),
        .overflow (bus.overflow)
    );

    assign bus.word_out   = fifo_dout[WW-1:0];
    assign bus.word_bytes = fifo_dout[FW-1:WW];
endmodule

// File: tb/tb_sobel_word_packer.sv
// Self-checking bench for sobel_word_packer: directed scenarios plus a randomized run against a queue model.
module tb_sobel_word_packer;
    typedef struct packed {
        logic [4:0]   n;
        logic [127:0] d;
    } wrec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] pend[$];
    wrec_t      mq[$];
    bit         m_ovf;

    sobel_word_packer_if #(.BYTES_PER_WORD(16), .FIFO_DEPTH(4)) bus();

    sobel_word_packer #(.BYTES_PER_WORD(16), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit r);
        bus.valid_in   = v;
        bus.data_in    = d;
        bus.flush      = f;
        bus.word_ready = r;
    endtask

    task automatic model_clear();
        pend.delete();
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic tick();
        bit    pop;
        bit    do_push;
        wrec_t w;
        pop     = (mq.size() != 0) && bus.word_ready;
        do_push = 1'b0;
        w       = '0;
        if (bus.valid_in) pend.push_back(bus.data_in);
        if (pend.size() == 16 || (bus.flush && pend.size() != 0)) begin
            w.n = 5'(pend.size());
            foreach (pend[i]) w.d[8*i +: 8] = pend[i];
            pend.delete();
            do_push = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < 4) mq.push_back(w);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.word_valid); end
        checks++; if (bus.word_out !== 128'h0) begin errors++; $display("FAIL rst_word got=%h exp=0", bus.word_out); end
        checks++; if (bus.word_bytes !== 5'd0) begin errors++; $display("FAIL rst_bytes got=%0d exp=0", bus.word_bytes); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", bus.fifo_level); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_full_word();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            tick();
            if (i == 14) begin
                checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL fw_early got=%b exp=0", bus.word_valid); end
            end
        end
        checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL fw_valid got=%b exp=1", bus.word_valid); end
        checks++; if (bus.word_out !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL fw_word got=%h", bus.word_out); end
        checks++; if (bus.word_bytes !== 5'd16) begin errors++; $display("FAIL fw_bytes got=%0d exp=16", bus.word_bytes); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL fw_popped got=%b exp=0", bus.word_valid); end
    endtask

    task automatic test_flush_partial();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL fp_valid got=%b exp=1", bus.word_valid); end
        checks++; if (bus.word_out !== 128'h0000000000000000000000A5A4A3A2A1) begin errors++; $display("FAIL fp_word got=%h", bus.word_out); end
        checks++; if (bus.word_bytes !== 5'd5) begin errors++; $display("FAIL fp_bytes got=%0d exp=5", bus.word_bytes); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL fp_empty_flush got=%b exp=0", bus.word_valid); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL fp_level got=%0d exp=0", bus.fifo_level); end
    endtask

    task automatic test_flush_last();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h1F, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL fl_level got=%0d exp=1", bus.fifo_level); end
        checks++; if (bus.word_bytes !== 5'd16) begin errors++; $display("FAIL fl_bytes got=%0d exp=16", bus.word_bytes); end
        checks++; if (bus.word_out !== 128'h1F1E1D1C1B1A19181716151413121110) begin errors++; $display("FAIL fl_word got=%h", bus.word_out); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        tick();
        checks++; if (bus.word_out !== 128'h5A) begin errors++; $display("FAIL fl_lane0 got=%h exp=5a", bus.word_out); end
        checks++; if (bus.word_bytes !== 5'd1) begin errors++; $display("FAIL fl_lane0_bytes got=%0d exp=1", bus.word_bytes); end
    endtask

    task automatic test_overflow();
        logic [127:0] gen [6];
        do_reset();
        for (int w = 0; w < 6; w++) begin
            gen[w] = '0;
            for (int i = 0; i < 16; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                gen[w][8*i +: 8] = b;
                drive(1'b1, b, 1'b0, 1'b0);
                tick();
            end
            checks++; if (bus.fifo_level !== 3'((w < 4) ? w + 1 : 4)) begin errors++; $display("FAIL ov_level w=%0d got=%0d", w, bus.fifo_level); end
            checks++; if (bus.overflow !== (w >= 4)) begin errors++; $display("FAIL ov_flag w=%0d got=%b", w, bus.overflow); end
        end
        checks++; if (bus.word_out !== gen[0]) begin errors++; $display("FAIL ov_hold got=%h exp=%h", bus.word_out, gen[0]); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.word_valid !== 1'b1 || bus.word_out !== gen[k] || bus.word_bytes !== 5'd16) begin
                errors++; $display("FAIL ov_drain k=%0d got=%h/%0d exp=%h/16", k, bus.word_out, bus.word_bytes, gen[k]);
            end
            tick();
        end
        checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL ov_empty got=%b exp=0", bus.word_valid); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ov_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 79; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL pp_pre_level got=%0d exp=4", bus.fifo_level); end
        drive(1'b1, 8'($urandom), 1'b0, 1'b1);
        tick();
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level got=%0d exp=4", bus.fifo_level); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", bus.overflow); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++; if (mq.size() == 0 || bus.word_out !== mq[0].d) begin errors++; $display("FAIL pp_drain k=%0d got=%h", k, bus.word_out); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 39; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.fifo_level !== 3'd2) begin errors++; $display("FAIL rm_pre_level got=%0d exp=2", bus.fifo_level); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.word_valid !== 1'b0 || bus.word_out !== 128'h0 || bus.word_bytes !== 5'd0 ||
                      bus.overflow !== 1'b0 || bus.fifo_level !== 3'd0) begin
            errors++; $display("FAIL rm_async got v=%b w=%h n=%0d o=%b l=%0d exp all 0",
                               bus.word_valid, bus.word_out, bus.word_bytes, bus.overflow, bus.fifo_level);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.word_out !== 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0 || bus.word_bytes !== 5'd16) begin
            errors++; $display("FAIL rm_clean got=%h/%0d", bus.word_out, bus.word_bytes);
        end
        checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL rm_level got=%0d exp=1", bus.fifo_level); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 8 : 1));
            tick();
            checks++; if (bus.word_valid !== (mq.size() != 0) || bus.fifo_level !== 3'(mq.size()) || bus.overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_ctrl c=%0d got v=%b l=%0d o=%b exp v=%b l=%0d o=%b",
                                   c, bus.word_valid, bus.fifo_level, bus.overflow, mq.size() != 0, mq.size(), m_ovf);
            end
            if (mq.size() != 0) begin
                checks++; if (bus.word_out !== mq[0].d || bus.word_bytes !== mq[0].n) begin
                    errors++; $display("FAIL rnd_head c=%0d got=%h/%0d exp=%h/%0d", c, bus.word_out, bus.word_bytes, mq[0].d, mq[0].n);
                end
            end
        end
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_clear();
        test_reset();
        test_full_word();
        test_flush_partial();
        test_flush_last();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sobel_word_packer.md
# sobel_word_packer

Output-side collector for the Sobel filter's 8-bit pixel stream: gathers `data_out`/`valid_out` bytes from `sobel_filter` into 128-bit little-endian words and presents them to the host write path over a valid/ready handshake. It absorbs the filter's lack of backpressure with a small word FIFO. A flush pushes out a zero-padded partial word at end of frame. A sticky flag reports dropped words.

## Interface
Parameters:
- `BYTES_PER_WORD`, 16: bytes per output word; word width = 8*BYTES_PER_WORD.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, >= 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_in`  in  8  pixel byte from `sobel_filter.data_out`.
- `valid_in`  in  1  byte valid; no backpressure, accepted every cycle it is high.
- `flush`  in  1  single-cycle pulse: emit the current partial word.
- `word_out`  out  128  packed word; byte k in bits [8k+7:8k].
- `word_bytes`  out  5  number of valid bytes in `word_out`, 1..16.
- `word_valid`  out  1  FIFO head valid.
- `word_ready`  in  1  host accepts head when `word_valid && word_ready`.
- `overflow`  out  1  sticky; set when a word is dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Assembly register `acc[127:0]` and byte counter `cnt` (0..15). On `valid_in`, `data_in` is written to lane `cnt`, and `cnt` increments.
- Word complete: `valid_in` with `cnt==15`, or `flush` with effective count > 0. The effective count is `cnt` plus 1 if `valid_in` is high in the same cycle.
- On completion:
  - Push `{acc with the new byte, unused lanes zeroed}` and the count to the FIFO.
  - Clear `acc` to 0 and `cnt` to 0.
- `flush` with `valid_in` high in the same cycle: the byte is included first, then the flush. `flush` with effective count 0 is a no-op, and no word is pushed.
- `flush` arriving when `cnt==15` and `valid_in` is high produces exactly one full word of 16 bytes.
- FIFO rules:
  - Pop on `word_valid && word_ready`.
  - Push while full and no pop in the same cycle: the word is dropped, `overflow` goes to 1, and it stays 1 until reset.
  - Push and pop in the same cycle while full: both succeed, and the level is unchanged.
- `word_out`/`word_bytes` hold stable while `word_valid && !word_ready`.
- Pointer wrap-around is modulo FIFO_DEPTH. Full/empty are distinguished by `fifo_level`.
- Reset, asynchronous and valid mid-word or mid-transfer:
  - Discards the partial word and all FIFO contents.
  - Output reset values: `word_valid`=0, `word_out`=0, `word_bytes`=0, `overflow`=0, `fifo_level`=0.

## Timing
- Latency: the completing byte is sampled at edge N, and `word_valid` is high after edge N (cycle N+1) if the FIFO was empty.
- A full word therefore appears 1 cycle after its 16th byte.
- Sustained throughput is 1 byte/cycle in, with at most 1 word per 16 cycles out. The host needs `word_ready` only 1/16 of the time, plus bursts up to FIFO_DEPTH.
- `fifo_level` updates on the same edge as the push or pop.
- `overflow` rises on the edge where the drop occurs.

## Structure
- Shared package `sobel_pkg`:
  - `PIXEL_W=8`, `WORD_W=128`, `BYTES_PER_WORD=16`.
  - Typedefs `pixel_t` (logic [7:0]) and `word_t` (logic [127:0]), reused by `sobel_filter`.
- Sub-module `sync_fifo`, parameterised on width and depth, holding `{word_bytes, word_out}` (133 bits). It has registered outputs, and its head is visible when not empty.
- Packing counter and accumulator are in the top module; no separate FSM is needed beyond `cnt`.

## Test plan
- Reset, then 16 bytes 0x00..0x0F on consecutive cycles with `word_ready`=1 → one word 0x0F0E…0100, `word_bytes`=16, `word_valid` high exactly 1 cycle after byte 0x0F.
- 5 bytes 0xA1..0xA5, then a `flush` pulse → word 0x…00A5A4A3A2A1 with upper 11 bytes zero, `word_bytes`=5. A second `flush` alone produces no word.
- `flush` in the same cycle as the 16th byte → exactly one word, `word_bytes`=16, `cnt` returns to 0, and the next byte lands in lane 0.
- Hold `word_ready`=0 and stream 6 words (FIFO_DEPTH=4) → `fifo_level` saturates at 4, `overflow`=1 after the 5th word completes. The first 4 words then drain in order with data intact; `overflow` stays 1.
- Full FIFO with `word_ready`=1 in the same cycle a word completes → no drop, `fifo_level` stays 4, `overflow` stays 0.
- Assert `rst` mid-word (after 7 bytes) with 2 words queued → all outputs go to 0 immediately. The next 16 bytes form a clean word starting at lane 0.
